// File: rtl/cnn_sched_pkg.sv
// Shared types and default sizing for the CNN core scheduler.
package cnn_sched_pkg;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned IMG_WORDS_DEF   = 64;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_RESP
  } sched_state_e;

endpackage

// File: rtl/cnn_core_sched_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[IDX_W'(cand)]) begin
        valid_o                = 1'b1;
        gnt_o[IDX_W'(cand)]    = 1'b1;
        idx_o                  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cnn_core_sched.sv
// Arbitrates requesters onto one CNN core: stream image in, pulse start,
// wait for completion or timeout, and hold the response until accepted.
module cnn_core_sched
  import cnn_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned IMG_WORDS   = IMG_WORDS_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned ADDR_W      = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               core_wr_en,
  output logic [ADDR_W-1:0]  core_wr_addr,
  output logic [DATA_W-1:0]  core_wr_data,
  output logic               core_enable,
  input  logic               core_done,
  input  logic [DATA_W-1:0]  core_value,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDX_W-1:0]   rsp_id,
  output logic [DATA_W-1:0]  rsp_value,
  output logic               rsp_err,
  output logic               busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_e       state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]  beat_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [IDX_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0]  rsp_value_q;
  logic               rsp_err_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [IDX_W-1:0]   ptr_d;
  logic [TMO_W-1:0]   tmo_d;
  logic               accept;
  logic               beat_last;
  logic               tmo_hit;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    tmo_d     = tmo_q + TMO_W'(1);
    tmo_hit   = (tmo_d == TMO_W'(TIMEOUT_CYC));
    accept    = in_valid && (state_q == ST_LOAD);
    beat_last = (beat_q == ADDR_W'(IMG_WORDS - 1));
  end

  // Write port is a pure decode of the handshake so data lands the same cycle.
  assign in_ready     = (state_q == ST_LOAD);
  assign core_wr_en   = accept;
  assign core_wr_addr = beat_q;
  assign core_wr_data = accept ? in_data : '0;
  assign core_enable  = (state_q == ST_START);
  assign rsp_valid    = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);
  assign gnt          = gnt_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_value    = rsp_value_q;
  assign rsp_err      = rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      rsp_id_q    <= '0;
      rsp_value_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_q    <= arb_gnt;
            rsp_id_q <= arb_idx;
            ptr_q    <= ptr_d;
            beat_q   <= '0;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (beat_last) begin
              beat_q  <= '0;
              state_q <= ST_START;
            end else begin
              beat_q <= beat_q + ADDR_W'(1);
            end
          end
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Completion wins over a timeout landing in the same cycle.
          if (core_done) begin
            rsp_value_q <= core_value;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else if (tmo_hit) begin
            rsp_value_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_core_sched.sv
// Directed self-checking bench for cnn_core_sched.
module tb_cnn_core_sched;

  localparam int TMO = 1000;
  localparam int IMG = 64;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        core_wr_en;
  logic [5:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic        core_enable;
  logic        core_done;
  logic [31:0] core_value;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_value;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  cnn_core_sched #(
    .NUM_REQ     (4),
    .IMG_WORDS   (IMG),
    .DATA_W      (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .core_wr_en   (core_wr_en),
    .core_wr_addr (core_wr_addr),
    .core_wr_data (core_wr_data),
    .core_enable  (core_enable),
    .core_done    (core_done),
    .core_value   (core_value),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_value    (rsp_value),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},      gnt, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"},    core_wr_en, 0);
    chk({tag, "_wr_addr"},  core_wr_addr, 0);
    chk({tag, "_wr_data"},  core_wr_data, 0);
    chk({tag, "_enable"},   core_enable, 0);
    chk({tag, "_rsp_vld"},  rsp_valid, 0);
    chk({tag, "_rsp_id"},   rsp_id, 0);
    chk({tag, "_rsp_val"},  rsp_value, 0);
    chk({tag, "_rsp_err"},  rsp_err, 0);
    chk({tag, "_busy"},     busy, 0);
  endtask

  // One job from grant to response handshake; abort_at>=0 resets mid-LOAD,
  // done_dly=0 means the core never finishes.
  task automatic job(input logic [3:0] r, input int idx, input bit gaps, input bit drop,
                     input int abort_at, input int done_dly, input logic [31:0] base,
                     input logic [31:0] step, input logic [31:0] val, input int hold);
    int b;
    int cyc;
    int n;
    bit v;
    logic [3:0]  onehot;
    logic [31:0] expv;
    req = r;
    @(negedge clk); #1;
    onehot = 4'b0001 << idx;
    chk("grant", gnt, onehot);
    chk("load_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    b = 0;
    cyc = 0;
    while (b < IMG && cyc < 400) begin
      @(negedge clk);
      cyc++;
      v = gaps ? cyc[0] : 1'b1;
      in_valid = v;
      in_data  = v ? base + step * 32'(b) : 32'hDEAD_BEEF;
      #1;
      chk("wr_en", core_wr_en, v);
      if (v) begin
        chk("wr_addr", core_wr_addr, 64'(b));
        chk("wr_data", core_wr_data, base + step * 32'(b));
        b++;
      end
      if (abort_at >= 0 && b == abort_at) break;
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      rst = 1'b0;
      #1;
      chk_zero("abort");
      req = 4'b0000;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    chk("beats", b, IMG);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = 32'h5555_AAAA;
    core_done  = 1'b1;
    core_value = 32'd55;
    if (drop) req = 4'b0000;
    #1;
    chk("start_pulse", core_enable, 1);
    chk("start_ready", in_ready, 0);
    chk("start_wr_en", core_wr_en, 0);
    n = 0;
    while (n < TMO + 100) begin
      @(negedge clk);
      n++;
      core_done = 1'b0;
      in_valid  = 1'b0;
      #1;
      if (rsp_valid) break;
      if (n == 1) chk("run_enable", core_enable, 0);
      if (done_dly > 0 && n == done_dly) begin
        core_done  = 1'b1;
        core_value = val;
      end
    end
    core_done = 1'b0;
    chk("rsp_latency", n, (done_dly > 0) ? done_dly + 1 : TMO + 1);
    expv = (done_dly > 0) ? val : 32'd0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, 64'(idx));
    chk("rsp_value", rsp_value, expv);
    chk("rsp_err", rsp_err, (done_dly > 0) ? 0 : 1);
    chk("rsp_gnt", gnt, onehot);
    repeat (hold) begin
      @(negedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, 64'(idx));
      chk("hold_value", rsp_value, expv);
      chk("hold_err", rsp_err, (done_dly > 0) ? 0 : 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_valid", rsp_valid, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    in_valid = 1'b0;
    in_data = '0;
    core_done = 1'b0;
    core_value = '0;
    rsp_ready = 1'b0;
    #2;
    rst = 1'b0;
    req = 4'b1111;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    core_done = 1'b1;
    @(negedge clk); #1;
    chk_zero("reset");
    @(negedge clk);
    req = 4'b0000;
    in_valid = 1'b0;
    in_data = '0;
    core_done = 1'b0;
    rst = 1'b1;

    // single job: 64 beats of 1, done 20 cycles after start with value 7
    job(4'b0001, 0, 1'b0, 1'b0, -1, 20, 32'd1, 32'd0, 32'd7, 0);
    // backpressure with req dropped mid-job and response held 10 cycles
    job(4'b0010, 1, 1'b1, 1'b1, -1, 30, 32'hB000_0000, 32'd1, 32'hCAFE_0002, 10);
    // reset after 30 beats aborts the job
    job(4'b0010, 1, 1'b0, 1'b0, 30, 0, 32'hC000_0000, 32'd3, 32'd0, 0);
    job(4'b0100, 2, 1'b0, 1'b0, -1, 5, 32'hD000_0000, 32'd1, 32'h0000_0044, 0);

    // reset in IDLE must return the pointer to 0
    rst = 1'b0;
    req = 4'b0000;
    #1;
    chk("idle_reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    job(4'b1111, 0, 1'b0, 1'b0, -1, 10, 32'h1000_0000, 32'd1, 32'h0000_0100, 0);
    job(4'b1111, 1, 1'b0, 1'b0, -1, 15, 32'h1100_0000, 32'd1, 32'h0000_0101, 1);
    job(4'b1111, 2, 1'b1, 1'b0, -1, 3,  32'h1200_0000, 32'd1, 32'h0000_0102, 2);
    job(4'b1111, 3, 1'b0, 1'b0, -1, 1,  32'h1300_0000, 32'd1, 32'h0000_0103, 0);
    // pointer wraps to 0; core never answers
    job(4'b1111, 0, 1'b0, 1'b0, -1, 0,  32'h1400_0000, 32'd1, 32'h0000_0000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_core_sched.md
CNN_CORE_SCHED -- requirements
Module: cnn_core_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one CNN core.
REQ-002 The block SHALL have parameter IMG_WORDS, default 64, the number of 32-bit image words per job.
REQ-003 The block SHALL have parameter DATA_W, default 32, the width of image words and of the result.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1000, the maximum number of RUN cycles before the job is aborted.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset (0 = reset).
REQ-007 The block SHALL have port req, input, NUM_REQ bits, per-requester job request.
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits, a one-hot grant held for the whole job.
REQ-009 The block SHALL have ports in_valid (input, 1), in_data (input, DATA_W) and in_ready (output, 1), carrying the image stream from the granted requester (muxed externally by gnt).
REQ-010 The block SHALL have ports core_wr_en (output, 1), core_wr_addr (output, log2(IMG_WORDS)) and core_wr_data (output, DATA_W), the core image-buffer write port.
REQ-011 The block SHALL have port core_enable, output, 1 bit, a one-cycle start pulse to the core.
REQ-012 The block SHALL have ports core_done (input, 1) and core_value (input, DATA_W), the core completion flag and prediction.
REQ-013 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, log2(NUM_REQ)), rsp_value (output, DATA_W) and rsp_err (output, 1), the response channel.
REQ-014 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, START, RUN and RESP.
REQ-016 In IDLE with any req bit set, the block SHALL select a requester round-robin starting at the pointer, register gnt and go to LOAD the next cycle; the pointer becomes the granted index+1 modulo NUM_REQ.
REQ-017 In LOAD, in_ready SHALL be 1; each cycle with in_valid&in_ready, core_wr_en=1, core_wr_data=in_data and core_wr_addr=the beat count, in the same cycle (combinational).
REQ-018 The beat counter SHALL start at 0 and increment per accepted beat; acceptance of beat IMG_WORDS-1 moves the FSM to START; in_valid gaps stall LOAD without limit.
REQ-019 In START, core_enable SHALL be 1 for exactly one cycle, then the FSM goes to RUN with the timeout counter cleared.
REQ-020 In RUN, core_done=1 SHALL capture core_value into rsp_value with rsp_err=0 and move to RESP.
REQ-021 In RUN, the timeout counter SHALL increment each cycle; if it reaches TIMEOUT_CYC without core_done, the block SHALL set rsp_value=0 and rsp_err=1 and move to RESP.
REQ-022 If core_done and the timeout occur in the same cycle, core_done SHALL take priority.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_id SHALL equal the granted index; rsp_id, rsp_value and rsp_err SHALL stay stable until rsp_ready.
REQ-024 When rsp_valid&rsp_ready, gnt SHALL clear and the FSM SHALL return to IDLE, so no job starts in that cycle.
REQ-025 Deasserting req mid-job SHALL be ignored: the job completes and the response is still issued.
REQ-026 core_done outside RUN SHALL be ignored.
REQ-027 in_ready SHALL be 0 outside LOAD.

Reset
REQ-028 While rst=0, the FSM SHALL be in IDLE and gnt, in_ready, core_wr_en, core_wr_addr, core_wr_data, core_enable, rsp_valid, rsp_id, rsp_value, rsp_err, busy, the round-robin pointer, the beat counter and the timeout counter SHALL all be 0.
REQ-029 A reset asserted mid-job SHALL abort the job immediately with no response; the first grant after reset goes to the lowest-index active req.

Structure
REQ-030 Package cnn_sched_pkg SHALL hold the FSM state enum and the defaults for NUM_REQ, IMG_WORDS, DATA_W and TIMEOUT_CYC.
REQ-031 A sub-module rr_arbiter SHALL implement the round-robin choice: req vector plus pointer in, one-hot grant and index out, purely combinational.

Verification
REQ-032 Single job: req=0001, 64 beats of value 1, core_done 20 cycles after core_enable with core_value=7 -> 64 writes at addresses 0..63, one core_enable pulse, then rsp_id=0, rsp_value=7, rsp_err=0.
REQ-033 Fairness: req=1111 held for 4 jobs -> grant order 0,1,2,3 and the pointer wraps to 0.
REQ-034 Timeout: core_done never asserted -> rsp_err=1 and rsp_value=0 exactly TIMEOUT_CYC cycles after RUN entry.
REQ-035 Backpressure: in_valid toggling 50% and rsp_ready held low 10 cycles -> no lost or duplicated beats, and the response fields stay stable while rsp_ready=0.
REQ-036 Reset at beat 30 of LOAD -> all outputs 0 on the same edge; a new job on req=0100 grants index 2 and completes normally.
